// File: rtl/dmem_pkg.sv
// Shared encodings and decode helpers for the data-memory load/store unit.
package dmem_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_RESP
  } lsu_state_e;

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    bad = 1'b1;
    case (f3)
      LS_B, LS_H, LS_W: bad = 1'b0;
      LS_BU, LS_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Only meaningful for legal codes; illegal codes are flagged separately.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (f3[1:0])
      2'b01:   mis = lane[0];
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    be = '0;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = '1;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data across lanes so the byte enables pick the right copy.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] w;
    w = wdata;
    case (f3[1:0])
      2'b00:   w = {4{wdata[7:0]}};
      2'b01:   w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Byte-enabled single-port word array with registered read; contents are never reset.
module dmem_sram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: lane alignment, extension, error detection and a one-deep response handshake.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned WAW = ADDR_WIDTH - 2;

  lsu_state_e  state_q, state_d;
  logic        accept;
  logic        req_err;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        err_q, err_d;
  logic        load_q, load_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;

  // Gating with rst_n keeps a store held during reset from reaching the array.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready && rst_n;
  assign req_err   = f3_illegal(req_we, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0]);
  assign mem_we    = (accept && req_we && !req_err) ? store_be(req_funct3, req_addr[1:0]) : '0;
  assign mem_wdata = store_lanes(req_funct3, req_wdata);

  dmem_sram #(
    .AW(WAW)
  ) u_sram (
    .clk_i   (clk),
    .en_i    (accept),
    .we_i    (mem_we),
    .addr_i  (req_addr[ADDR_WIDTH-1:2]),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      f3_q    <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      load_q  <= load_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    err_d  = err_q;
    load_d = load_q;
    f3_d   = f3_q;
    lane_d = lane_q;
    if (accept) begin
      err_d  = req_err;
      load_d = !req_we && !req_err;
      f3_d   = req_funct3;
      lane_d = req_addr[1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RESP;
      ST_RESP: if (rsp_ready && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    rsp_valid = (state_q == ST_RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = '0;
    byte_sel  = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel  = mem_rdata[{lane_q[1], 4'b0000} +: 16];
    if (rsp_valid && load_q) begin
      case (f3_q)
        LS_B:    rsp_rdata = {{24{byte_sel[7]}}, byte_sel};
        LS_BU:   rsp_rdata = {24'h0, byte_sel};
        LS_H:    rsp_rdata = {{16{half_sel[15]}}, half_sel};
        LS_HU:   rsp_rdata = {16'h0, half_sel};
        default: rsp_rdata = mem_rdata;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized and directed bench for dmem_lsu against a byte-array reference model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_total = 0;
  int n_bad   = 0;
  int n_acc   = 0;

  logic [7:0]  mdl [0:255];
  logic        pend = 1'b0;
  logic [31:0] q_rdata;
  logic        q_err;
  logic [31:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  dmem_lsu #(
    .ADDR_WIDTH(14),
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: size from funct3, legality by table, memory as bytes.
  task automatic model(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    int nb;
    logic legal;
    logic [31:0] v;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!we && (f3 == 3'd4 || f3 == 3'd5));
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = !legal || (a % nb != 0);
    rd = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nb; i++) mdl[a + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(mdl[a + i]) << (8 * i));
      if (nb < 4 && f3[2] == 1'b0 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
      rd = v;
    end
  endtask

  // Inputs are driven before the call; checks at negedge, bookkeeping at posedge.
  task automatic step();
    logic exp_rr, acc, ret;
    @(negedge clk);
    exp_rr = !pend || rsp_ready;
    check_eq("req_ready", 32'(req_ready), 32'(exp_rr));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(pend));
    if (pend) begin
      check_eq("rsp_rdata", rsp_rdata, q_rdata);
      check_eq("rsp_err", 32'(rsp_err), 32'(q_err));
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
    end
    acc = req_valid && exp_rr;
    ret = pend && rsp_ready;
    @(posedge clk);
    if (ret) pend = 1'b0;
    if (acc) begin
      model(req_we, req_funct3, int'(req_addr), req_wdata, q_rdata, q_err);
      pend = 1'b1;
      n_acc++;
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = 14'(a);
    req_wdata  = wd;
  endtask

  task automatic txn(input logic we, input logic [2:0] f3, input int a, input logic [31:0] wd);
    drive(we, f3, a, wd);
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    int acc0;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    drive(1'b0, 3'd0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    check_eq("rst_err", 32'(rsp_err), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int w = 0; w < 64; w++) txn(1'b1, 3'd2, 4 * w, 32'h0);

    txn(1'b1, 3'd2, 'h010, 32'hDEADBEEF);
    txn(1'b0, 3'd2, 'h010, 32'h0);
    check_eq("sw_lw_data", last_rdata, 32'hDEADBEEF);
    check_eq("sw_lw_err", 32'(last_err), 32'h0);

    txn(1'b1, 3'd2, 'h010, 32'h0);
    txn(1'b1, 3'd0, 'h013, 32'h80);
    txn(1'b0, 3'd0, 'h013, 32'h0);
    check_eq("lb_sign", last_rdata, 32'hFFFFFF80);
    txn(1'b0, 3'd4, 'h013, 32'h0);
    check_eq("lbu_zero", last_rdata, 32'h00000080);
    txn(1'b0, 3'd2, 'h010, 32'h0);
    check_eq("lw_after_sb", last_rdata, 32'h80000000);

    txn(1'b1, 3'd2, 'h020, 32'hCAFEF00D);
    txn(1'b1, 3'd1, 'h021, 32'h1234);
    check_eq("sh_mis_err", 32'(last_err), 32'h1);
    txn(1'b0, 3'd2, 'h020, 32'h0);
    check_eq("no_write_mis", last_rdata, 32'hCAFEF00D);
    txn(1'b0, 3'd2, 'h022, 32'h0);
    check_eq("lw_mis_err", 32'(last_err), 32'h1);
    check_eq("lw_mis_data", last_rdata, 32'h0);

    // Stall three cycles with a request waiting, then stream four loads.
    acc0 = n_acc;
    drive(1'b0, 3'd2, 'h010, 32'h0);
    req_valid = 1'b1; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    drive(1'b0, 3'd2, 'h014, 32'h0);
    repeat (3) begin
      step();
      check_eq("stall_data", last_rdata, 32'h80000000);
    end
    rsp_ready = 1'b1;
    step();
    drive(1'b0, 3'd2, 'h018, 32'h0);
    step();
    drive(1'b0, 3'd2, 'h01C, 32'h0);
    step();
    req_valid = 1'b0;
    step();
    check_eq("b2b_accepts", 32'(n_acc - acc0), 32'd4);
    step();

    for (int c = 0; c < 500; c++) begin
      req_valid = ($urandom % 4) != 0;
      rsp_ready = ($urandom % 3) != 0;
      drive(1'($urandom % 2), 3'($urandom % 8), int'($urandom_range(0, 255)), $urandom);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    step();

    txn(1'b1, 3'd2, 'h010, 32'h5A5AA5A5);
    drive(1'b0, 3'd2, 'h010, 32'h0);
    req_valid = 1'b1; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_valid", 32'(rsp_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(rsp_valid), 32'h0);
    check_eq("async_rdata", rsp_rdata, 32'h0);
    check_eq("async_err", 32'(rsp_err), 32'h0);
    pend = 1'b0;
    drive(1'b1, 3'd2, 'h010, 32'h11111111);
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 3'd2, 'h010, 32'h0);
    check_eq("mem_persist", last_rdata, 32'h5A5AA5A5);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 14, byte-address width; word depth = 2**(ADDR_WIDTH-2).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 The block SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_funct3  input  3  RV32I size/sign code.
REQ-009 The block SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-010 The block SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid  output  1  response present.
REQ-012 The block SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-013 The block SHALL have port rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err  output  1  misaligned or illegal funct3.

Function
REQ-015 The block SHALL drive req_ready = !rsp_valid || rsp_ready, giving at most one outstanding response.
REQ-016 On an accept edge, a legal store SHALL write only the selected byte lanes: SB = 1 lane at addr[1:0]; SH = 2 lanes at addr[1]*2; SW = all 4 lanes.
REQ-017 On an accept edge, a legal load SHALL register the addressed word, with rsp_valid high on the following cycle (latency 1).
REQ-018 The load result SHALL be extracted by lane: LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-019 Misalignment SHALL be defined as halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-020 Illegal funct3 SHALL be defined as load 011/110/111, or store with any value other than 000/001/010.
REQ-021 Misaligned or illegal requests SHALL perform no write, and SHALL produce rsp_err=1 with rsp_rdata=0 one cycle after acceptance.
REQ-022 While rsp_valid && !rsp_ready, rsp_valid, rsp_rdata and rsp_err SHALL hold stable and no new request SHALL be accepted.
REQ-023 On a cycle with rsp_valid && rsp_ready && req_valid, the block SHALL retire the old response and accept the new request on the same edge, giving back-to-back throughput of 1 request per cycle.
REQ-024 A load accepted on the cycle after a store to the same word SHALL return the updated data.
REQ-025 rsp_valid SHALL drop the cycle after a handshake with no new acceptance.
REQ-026 The controller SHALL have states IDLE (no response pending) and RESP (rsp_valid=1). IDLE->RESP on accept; RESP->IDLE on rsp_ready without accept; RESP->RESP on rsp_ready with accept or on !rsp_ready.

Reset
REQ-027 While rst_n is low, rsp_valid=0, rsp_rdata=0, rsp_err=0 and state=IDLE, asynchronously.
REQ-028 The memory array SHALL NOT be reset, and its contents SHALL persist across reset.
REQ-029 A store presented while rst_n is low SHALL NOT be committed.
REQ-030 A response pending when reset asserts SHALL be discarded.

Structure
REQ-031 Package dmem_pkg SHALL hold the funct3 encodings LS_B=000, LS_H=001, LS_W=010, LS_BU=100, LS_HU=101 and the state enum type.
REQ-032 Sub-module dmem_sram SHALL be a byte-enabled synchronous single-port word array with 4-bit write enable and registered read.
REQ-033 dmem_lsu SHALL hold the lane alignment, extension, error detection and handshake FSM.

Verification
REQ-034 SW 0xDEADBEEF @0x010, then LW @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 1 cycle after acceptance.
REQ-035 SB 0x80 @0x013 over 0x00000000, then LB @0x013 -> 0xFFFFFF80, LBU @0x013 -> 0x00000080, LW @0x010 -> 0x80000000.
REQ-036 SH 0x1234 @0x021 -> rsp_err=1, and a following LW @0x020 still returns the prior value; LW @0x022 -> rsp_err=1, rsp_rdata=0.
REQ-037 Hold rsp_ready=0 for 3 cycles after a load -> rsp fields stable and req_ready=0 throughout; then rsp_ready=1 with req_valid=1 -> next request accepted the same edge, giving 4 back-to-back loads in 5 cycles.
REQ-038 Assert rst_n=0 while rsp_valid=1 -> rsp_valid=0 immediately; after release, LW of a previously written address returns the pre-reset data.
